// File: rtl/alu_stream_if.sv
// Handshake and data bundle for alu_stream: operation request in, registered result plus flags out.
interface alu_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, carry, ovf, err
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, zero, carry, ovf, err
  );
endinterface

// File: rtl/alu_stream.sv
// Streaming ALU: single-cycle logic/arith/shift ops and a WIDTH-cycle shift-add multiplier,
// with valid/ready handshakes on both sides and a registered result held until consumed.
module alu_stream #(
  parameter int unsigned WIDTH = 8,
  parameter bit          SAT   = 1'b0
) (
  input logic         clk,
  input logic         rst,
  alu_stream_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpShl = 4'd5;
  localparam logic [3:0] OpShr = 4'd6;
  localparam logic [3:0] OpMul = 4'd7;
  localparam logic [3:0] OpSra = 4'd8;

  localparam logic [WIDTH-1:0] SMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMin = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d;
  logic               zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;

  logic               in_ready, accept;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf, alu_err;
  logic [WIDTH:0]     ext;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign shamt    = bus.b[SW-1:0];
  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    ext       = '0;
    case (bus.opcode)
      OpAdd: begin
        ext       = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res   = ext[WIDTH-1:0];
        alu_carry = ext[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        ext       = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res   = ext[WIDTH-1:0];
        alu_carry = ext[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpAnd:   alu_res = bus.a & bus.b;
      OpOr:    alu_res = bus.a | bus.b;
      OpXor:   alu_res = bus.a ^ bus.b;
      OpShl:   alu_res = bus.a << shamt;
      OpShr:   alu_res = bus.a >> shamt;
      OpSra:   alu_res = $signed(bus.a) >>> shamt;
      OpMul:   ;
      default: alu_err = 1'b1;
    endcase
    // Only ADD/SUB can raise ovf, so this clamp never touches other ops.
    if (SAT && alu_ovf) alu_res = bus.a[WIDTH-1] ? SMin : SMax;
  end

  // One radix-2 step: low half holds the remaining multiplier bits, shifted out LSB first.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    case (state_q)
      StBusy: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d  = StDone;
          result_d = mul_next[WIDTH-1:0];
          hi_d     = mul_next[2*WIDTH-1:WIDTH];
          zero_d   = (mul_next == '0);
          carry_d  = |mul_next[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
      StDone: if (bus.out_ready) state_d = StIdle;
      default: ;
    endcase

    if (accept) begin
      if (bus.opcode == OpMul) begin
        state_d = StBusy;
        cnt_d   = '0;
        prod_d  = {{WIDTH{1'b0}}, bus.b};
        mcand_d = bus.a;
      end else begin
        state_d  = StDone;
        result_d = alu_res;
        hi_d     = '0;
        zero_d   = ~alu_err & (alu_res == '0);
        carry_d  = alu_carry;
        ovf_d    = alu_ovf;
        err_d    = alu_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.result_hi = hi_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
endmodule
